pwm_sched: RTL
==============

Name: pwm_sched

Overview:
Central controller for a bank of pwm channel instances. It generates the shared free-running period_count and holds every channel's configuration in shadow registers written by the host. It applies shadow-to-active updates atomically on a period boundary, so no channel sees a torn period/phase/duty change. It also sequences start/stop so that PWM outputs only stop at a period boundary.

Parameters:
NUM_CH, 4, number of pwm channels driven (1..8)
DEF_PERIOD, 16'd100, reset value of the shadow and active period

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
run_req  input  1  level; high requests counting, low requests stop at next boundary
wr_en  input  1  shadow register write strobe
wr_ch  input  3  target channel; values >= NUM_CH ignored (except wr_sel=2)
wr_sel  input  2  0=phase, 1=duty_cycle, 2=period (global, wr_ch ignored), 3=ctrl
wr_data  input  16  write data; for ctrl: [2:0]=trig_count, [3]=enable, [4]=invert, [5]=initial_val
commit  input  1  pulse; request shadow->active transfer
commit_pending  output  1  commit accepted, waiting for boundary
commit_done  output  1  one-cycle pulse when active registers updated
running  output  1  high in RUN and STOP_WAIT
period_count  output  16  shared counter to all channels
period_out  output  16  active period
phase_out  output  16*NUM_CH  active phase, channel i at [16i+15:16i]
duty_out  output  16*NUM_CH  active duty_cycle
trig_out  output  3*NUM_CH  active trig_count
enable_out  output  NUM_CH  active enable gated by running
invert_out  output  NUM_CH  active invert
initial_out  output  NUM_CH  active initial_val

Behaviour:
- Reset (async, rst=1): state IDLE, period_count=0, commit_pending=0, commit_done=0, running=0. All shadow and active phase/duty/trig/enable/invert/initial are 0. Shadow and active period = DEF_PERIOD. All outputs are registered.
- Effective period: eff = (period_out==0) ? 1 : period_out.
- Boundary: a RUN/STOP_WAIT cycle where period_count == eff-1. On that clock period_count becomes 0; otherwise it increments by 1. With eff=1, every cycle is a boundary and the count stays at 0.
- States:
  - IDLE: period_count held at 0, enable_out=0. If run_req=1, go to RUN next clk; the count starts from 0, so the first RUN cycle shows 0.
  - RUN: counting. If run_req=0, go to STOP_WAIT; counting continues.
  - STOP_WAIT: counting. If run_req=1 before the boundary, return to RUN with no interruption. At the boundary with run_req=0, go to IDLE, period_count=0, enable_out=0.
- Shadow writes: when wr_en=1, the shadow field selected by wr_sel/wr_ch takes wr_data on the next clk. Writes to an invalid channel have no effect. Writes never touch active registers directly.
- Commit in IDLE: active<=shadow on the next clk, with commit_done pulsed on that same clk. commit_pending is not asserted.
- Commit in RUN/STOP_WAIT:
  - commit_pending=1 from the next clk.
  - At the next boundary: active<=shadow, commit_pending=0, and commit_done=1 for one cycle, coincident with period_count=0.
  - The new period takes effect for the period starting at that 0.
- Commit on a boundary cycle while not pending: the request is pending and is not applied until the following boundary. This keeps the full-period guarantee.
- commit while already pending: no additional effect.
- Commit arriving on the same cycle as a pending transfer completes: treated as a new pending request.
- wr_en and commit in the same cycle: the write is included in that commit.
- Writes while pending: allowed. The transfer copies whatever the shadow holds at the boundary clk, including a write landing on that clk.
- Stopping with a commit pending: the transfer happens at the stopping boundary.
- Shrinking period: if the active period shrinks, the change happens only at a boundary where the count resets to 0. period_count therefore never exceeds eff-1.
- enable_out[i] = active enable[i] & running. The other active fields are driven to the outputs unconditionally.

Test Plan:
- Reset/defaults: assert rst mid-count with period_count=37 -> outputs immediately return to reset state; period_out=100, period_count=0, enable_out=0, commit_pending=0.
- Counting/wrap: set period=5, commit in IDLE, run_req=1 -> period_count sequence 0,1,2,3,4,0,1; period=0 -> count stays 0 with a boundary every cycle.
- Synchronous commit: while running with period=10, write ch1 duty=3 and commit at count=4 -> commit_pending=1 from count 5 to 9; duty_out[ch1] changes and commit_done pulses on the clk where count=0. A commit issued exactly at count=9 is applied at the following wrap, 10 cycles later.
- Period change: with period=10 running, commit period=4 at count=7 -> counts 8,9,0,1,2,3,0; period_count never reaches 10 or more.
- Stop sequencing: deassert run_req at count=2 with period=8 -> running stays 1 through count 7, then IDLE with count=0 and enable_out=0. Re-asserting run_req at count=5 instead -> no stop and continuous counting.
- Write/commit collisions: wr_en to ch2 phase=9 plus commit in the same cycle -> phase_out[ch2]=9 after the boundary. A write to wr_ch=7 with NUM_CH=4 -> no register changes.

Source files
------------

// File: rtl/pwm_sched.sv
// rtl/pwm_sched.sv - shared period counter, shadow/active channel config and run/stop sequencing
module pwm_sched #(
    parameter int          NUM_CH     = 4,
    parameter logic [15:0] DEF_PERIOD = 16'd100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run_req,
    input  logic                   wr_en,
    input  logic [2:0]             wr_ch,
    input  logic [1:0]             wr_sel,
    input  logic [15:0]            wr_data,
    input  logic                   commit,
    output logic                   commit_pending,
    output logic                   commit_done,
    output logic                   running,
    output logic [15:0]            period_count,
    output logic [15:0]            period_out,
    output logic [16*NUM_CH-1:0]   phase_out,
    output logic [16*NUM_CH-1:0]   duty_out,
    output logic [3*NUM_CH-1:0]    trig_out,
    output logic [NUM_CH-1:0]      enable_out,
    output logic [NUM_CH-1:0]      invert_out,
    output logic [NUM_CH-1:0]      initial_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP_WAIT = 2'd2} state_t;

    typedef struct packed {
        logic [15:0] phase;
        logic [15:0] duty;
        logic [2:0]  trig;
        logic        en;
        logic        inv;
        logic        init;
    } cfg_t;

    state_t            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       per_sh_q, per_sh_d;
    logic [15:0]       per_act_q, per_act_d;
    logic              pending_q, pending_d;
    logic              done_q, done_d;
    logic              running_q, running_d;
    logic [NUM_CH-1:0] enable_q, enable_d;
    cfg_t              sh_q  [NUM_CH];
    cfg_t              sh_d  [NUM_CH];
    cfg_t              act_q [NUM_CH];
    cfg_t              act_d [NUM_CH];

    logic [15:0]       eff;
    logic              boundary;
    logic              apply;

    assign eff      = (per_act_q == 16'd0) ? 16'd1 : per_act_q;
    assign boundary = (state_q != IDLE) && (count_q == eff - 16'd1);

    always_comb begin
        sh_d     = sh_q;
        per_sh_d = per_sh_q;
        if (wr_en) begin
            if (wr_sel == 2'd2) begin
                per_sh_d = wr_data;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (wr_ch == 3'(i)) begin
                        case (wr_sel)
                            2'd0: sh_d[i].phase = wr_data;
                            2'd1: sh_d[i].duty  = wr_data;
                            default: begin
                                sh_d[i].trig = wr_data[2:0];
                                sh_d[i].en   = wr_data[3];
                                sh_d[i].inv  = wr_data[4];
                                sh_d[i].init = wr_data[5];
                            end
                        endcase
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            RUN: begin
                count_d = boundary ? 16'd0 : count_q + 16'd1;
                state_d = run_req ? RUN : STOP_WAIT;
            end
            STOP_WAIT: begin
                count_d = boundary ? 16'd0 : count_q + 16'd1;
                if (run_req)       state_d = RUN;
                else if (boundary) state_d = IDLE;
            end
            default: begin
                count_d = 16'd0;
                state_d = run_req ? RUN : IDLE;
            end
        endcase
        running_d = (state_d != IDLE);
    end

    // Shadow next-state is copied so a write landing on the transfer clock is included.
    always_comb begin
        apply     = 1'b0;
        pending_d = pending_q;
        if (state_q == IDLE) begin
            apply     = commit | pending_q;
            pending_d = 1'b0;
        end else if (pending_q && boundary) begin
            apply     = 1'b1;
            pending_d = commit;
        end else begin
            pending_d = pending_q | commit;
        end
        act_d     = act_q;
        per_act_d = per_act_q;
        if (apply) begin
            act_d     = sh_d;
            per_act_d = per_sh_d;
        end
        done_d = apply;
        for (int i = 0; i < NUM_CH; i++) begin
            enable_d[i] = act_d[i].en & running_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= 16'd0;
            per_sh_q  <= DEF_PERIOD;
            per_act_q <= DEF_PERIOD;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            enable_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sh_q[i]  <= '0;
                act_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            per_sh_q  <= per_sh_d;
            per_act_q <= per_act_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            running_q <= running_d;
            enable_q  <= enable_d;
            sh_q      <= sh_d;
            act_q     <= act_d;
        end
    end

    assign commit_pending = pending_q;
    assign commit_done    = done_q;
    assign running        = running_q;
    assign period_count   = count_q;
    assign period_out     = per_act_q;
    assign enable_out     = enable_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign phase_out[16*g +: 16] = act_q[g].phase;
        assign duty_out[16*g +: 16]  = act_q[g].duty;
        assign trig_out[3*g +: 3]    = act_q[g].trig;
        assign invert_out[g]         = act_q[g].inv;
        assign initial_out[g]        = act_q[g].init;
    end

endmodule
